crc_frame_ctrl: RTL and testbench

//   Byte-level front end and sequencer for the serial CRC engine (ports DATA, Active, CRC, Valid).
//   - Accepts a frame of bytes over a valid/ready stream and serialises each byte MSB-first into the engine with Active held.
//   - Drops Active after the last byte, then captures the engine's serial CRC output into a parallel result.
//   - Sits between the packet/framing logic and the CRC engine.

---
 rtl/crc_frame_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-stream front end and sequencer for a serial CRC engine.
// Serialises each accepted byte MSB-first onto crc_data with crc_active held,
// then collects CRC_W serial CRC bits back into a parallel result.
// Optional feature macro: CRC_CTRL_TIMEOUT_EN (WAIT-state timeout counter).
module crc_frame_ctrl #(
    parameter int unsigned CRC_W       = 8,
    parameter int unsigned MAX_BYTES   = 16,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic [7:0]                       in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic                             crc_data,
    output logic                             crc_active,
    input  logic                             crc_bit,
    input  logic                             crc_valid,
    output logic [CRC_W-1:0]                 crc_result,
    output logic                             result_valid,
    output logic [$clog2(MAX_BYTES+1)-1:0]   frame_bytes,
    output logic                             busy,
    output logic                             error
);

    localparam int unsigned BW = $clog2(MAX_BYTES + 1);
    // One spare count so an overlength accept (MAX_BYTES+1) is representable.
    localparam int unsigned CW = $clog2(MAX_BYTES + 2);
    localparam int unsigned KW = $clog2(CRC_W + 1);
    localparam int unsigned DW = $clog2(2 * CRC_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_COLLECT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sreg_q, sreg_d;
    logic              last_q, last_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [CRC_W-1:0]  col_q, col_d;
    logic [KW-1:0]     col_cnt_q, col_cnt_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              vld_prev_q, vld_prev_d;
    logic [CRC_W-1:0]  crc_result_q, crc_result_d;
    logic [BW-1:0]     frame_bytes_q, frame_bytes_d;
    logic              error_q, error_d;
    logic              run_q, run_d;
    logic [CRC_W-1:0]  col_sh;

`ifdef CRC_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    // Output decode: everything comes from flops, no input-to-output paths.
    always_comb begin
        crc_active   = (state_q == S_SHIFT);
        crc_data     = sreg_q[7];
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE);
        in_ready     = run_q && ((state_q == S_IDLE) ||
                       ((state_q == S_SHIFT) && (bit_cnt_q == 3'd7) && !last_q));
        error        = error_q;
        crc_result   = crc_result_q;
        frame_bytes  = frame_bytes_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        last_d        = last_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        col_d         = col_q;
        col_cnt_d     = col_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        vld_prev_d    = crc_valid;
        crc_result_d  = crc_result_q;
        frame_bytes_d = frame_bytes_q;
        error_d       = 1'b0;
        run_d         = 1'b1;
        col_sh        = (col_q << 1) | CRC_W'(crc_bit);
`ifdef CRC_CTRL_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    sreg_d     = in_data;
                    last_d     = in_last;
                    bit_cnt_d  = '0;
                    byte_cnt_d = CW'(1);
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sreg_d      = {sreg_q[6:0], 1'b0};
                bit_cnt_d   = bit_cnt_q + 3'd1;
                col_cnt_d   = '0;
                drain_cnt_d = '0;
`ifdef CRC_CTRL_TIMEOUT_EN
                wait_cnt_d  = '0;
`endif
                if (bit_cnt_q == 3'd7) begin
                    if (last_q) begin
                        state_d = S_WAIT;
                    end else if (in_valid) begin
                        sreg_d     = in_data;
                        last_d     = in_last;
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        if (byte_cnt_d > CW'(MAX_BYTES)) begin
                            error_d = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end

            // WAIT and COLLECT share the capture path; they differ only in how
            // a cycle without crc_valid is treated. The result register is
            // loaded on the edge into DONE so it is already valid while
            // result_valid is high.
            S_WAIT, S_COLLECT: begin
                if (crc_valid) begin
                    col_d     = col_sh;
                    col_cnt_d = col_cnt_q + KW'(1);
                    if (col_cnt_d == KW'(CRC_W)) begin
                        crc_result_d  = col_sh;
                        frame_bytes_d = byte_cnt_q[BW-1:0];
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else if (state_q == S_COLLECT) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef CRC_CTRL_TIMEOUT_EN
                else begin
                    if (wait_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TW'(1);
                    end
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                if (vld_prev_q && !crc_valid) begin
                    frame_bytes_d = byte_cnt_q[BW-1:0];
                    state_d       = S_IDLE;
                end else if (crc_valid) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == DW'(2 * CRC_W - 1)) begin
                    frame_bytes_d = byte_cnt_q[BW-1:0];
                    state_d       = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronous active-low reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sreg_q        <= '0;
            last_q        <= 1'b0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            col_q         <= '0;
            col_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            vld_prev_q    <= 1'b0;
            crc_result_q  <= '0;
            frame_bytes_q <= '0;
            error_q       <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            last_q        <= last_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            col_q         <= col_d;
            col_cnt_q     <= col_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            vld_prev_q    <= vld_prev_d;
            crc_result_q  <= crc_result_d;
            frame_bytes_q <= frame_bytes_d;
            error_q       <= error_d;
            run_q         <= run_d;
        end
    end

`ifdef CRC_CTRL_TIMEOUT_EN
    // WAIT-state timeout counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: table-driven frames plus hand-written corner
// sequences; shifted bits and results are checked against scoreboard queues.
module tb_crc_frame_ctrl;

    localparam int unsigned CRC_W       = 8;
    localparam int unsigned MAX_BYTES   = 16;
    localparam int unsigned TIMEOUT_CYC = 32;
    localparam int unsigned BW          = $clog2(MAX_BYTES + 1);

    logic             CLK = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             crc_data;
    logic             crc_active;
    logic             crc_bit = 1'b0;
    logic             crc_valid = 1'b0;
    logic [CRC_W-1:0] crc_result;
    logic             result_valid;
    logic [BW-1:0]    frame_bytes;
    logic             busy;
    logic             error;

    crc_frame_ctrl #(
        .CRC_W       (CRC_W),
        .MAX_BYTES   (MAX_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .crc_data     (crc_data),
        .crc_active   (crc_active),
        .crc_bit      (crc_bit),
        .crc_valid    (crc_valid),
        .crc_result   (crc_result),
        .result_valid (result_valid),
        .frame_bytes  (frame_bytes),
        .busy         (busy),
        .error        (error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned n;
        logic [31:0] bytes;
        logic [7:0]  crc;
        int unsigned k;
        int unsigned exp_err;
        logic [7:0]  exp_crc;
        int unsigned exp_fb;
    } vec_t;

    typedef struct {
        logic [7:0]  crc;
        int unsigned fb;
    } res_t;

    vec_t        vecs[7];
    logic        exp_bits[$];
    res_t        exp_res[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned act_cnt = 0;
    int unsigned rdy_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned rv_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge against the scoreboard, return at posedge+1.
    task automatic cyc();
        logic b;
        res_t r;
        @(negedge CLK);
        if (crc_active) begin
            act_cnt++;
            chk("bit_queue_nonempty", 32'(exp_bits.size() != 0), 32'd1);
            if (exp_bits.size() != 0) begin
                b = exp_bits.pop_front();
                chk("crc_data_bit", 32'(crc_data), 32'(b));
            end
        end
        if (in_ready && busy) rdy_cnt++;
        if (error) err_cnt++;
        if (result_valid) begin
            rv_cnt++;
            chk("result_queue_nonempty", 32'(exp_res.size() != 0), 32'd1);
            if (exp_res.size() != 0) begin
                r = exp_res.pop_front();
                chk("crc_result", 32'(crc_result), 32'(r.crc));
                chk("frame_bytes", 32'(frame_bytes), r.fb);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!in_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("ready_before_frame", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (busy && n < limit) begin
            cyc();
            n++;
        end
        chk("busy_clears", 32'(busy), 32'd0);
    endtask

    task automatic engine(input logic [7:0] bits, input int unsigned k);
        for (int i = 0; i < int'(k); i++) begin
            crc_valid = 1'b1;
            crc_bit   = bits[7-i];
            cyc();
        end
        crc_valid = 1'b0;
        crc_bit   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned a0, r0, e0, v0;
        logic [7:0] b;
        wait_ready();
        a0 = act_cnt; r0 = rdy_cnt; e0 = err_cnt; v0 = rv_cnt;
        for (int i = 0; i < int'(v.n); i++) begin
            b = v.bytes[8*i +: 8];
            if (i > 0) repeat (7) cyc();
            in_valid = 1'b1;
            in_data  = b;
            in_last  = (i == int'(v.n) - 1);
            push_byte(b);
            cyc();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        repeat (8) cyc();
        if (v.k == CRC_W) exp_res.push_back('{crc: v.crc, fb: v.n});
        engine(v.crc, v.k);
        repeat (3) cyc();
        chk("active_cycles", act_cnt - a0, 8 * v.n);
        chk("ready_in_shift", rdy_cnt - r0, v.n - 1);
        chk("error_pulses", err_cnt - e0, v.exp_err);
        chk("result_pulses", rv_cnt - v0, (v.exp_err != 0) ? 0 : 1);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("crc_result_hold", 32'(crc_result), 32'(v.exp_crc));
        chk("frame_bytes_hold", 32'(frame_bytes), v.exp_fb);
    endtask

    initial begin
        int unsigned a0, r0, e0, v0;
        int unsigned hit;
        logic [7:0] b;

        vecs[0] = '{n: 1, bytes: 32'h000000A5, crc: 8'hCA, k: 8, exp_err: 0, exp_crc: 8'hCA, exp_fb: 1};
        vecs[1] = '{n: 2, bytes: 32'h0000F03C, crc: 8'h5E, k: 8, exp_err: 0, exp_crc: 8'h5E, exp_fb: 2};
        vecs[2] = '{n: 3, bytes: 32'h00FF8001, crc: 8'h00, k: 8, exp_err: 0, exp_crc: 8'h00, exp_fb: 3};
        vecs[3] = '{n: 4, bytes: 32'hEFBEADDE, crc: 8'hFF, k: 8, exp_err: 0, exp_crc: 8'hFF, exp_fb: 4};
        vecs[4] = '{n: 1, bytes: 32'h00000012, crc: 8'h0F, k: 3, exp_err: 1, exp_crc: 8'hFF, exp_fb: 4};
        vecs[5] = '{n: 2, bytes: 32'h0000FF00, crc: 8'h81, k: 7, exp_err: 1, exp_crc: 8'hFF, exp_fb: 4};
        vecs[6] = '{n: 1, bytes: 32'h000000FF, crc: 8'h3A, k: 8, exp_err: 0, exp_crc: 8'h3A, exp_fb: 1};

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(crc_active), 32'd0);
        chk("rst_data", 32'(crc_data), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_crc_result", 32'(crc_result), 32'd0);
        chk("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Underrun: 0x55 without last, nothing offered at bit 7
        wait_ready();
        a0 = act_cnt; r0 = rdy_cnt; e0 = err_cnt; v0 = rv_cnt;
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
        push_byte(8'h55);
        cyc();
        in_valid = 1'b0;
        repeat (8) cyc();
        engine(8'hA7, 8);
        wait_idle(40);
        cyc();
        chk("underrun_active", act_cnt - a0, 32'd8);
        chk("underrun_ready", rdy_cnt - r0, 32'd1);
        chk("underrun_error", err_cnt - e0, 32'd1);
        chk("underrun_no_result", rv_cnt - v0, 32'd0);
        chk("underrun_frame_bytes", 32'(frame_bytes), 32'd1);
        chk("underrun_crc_hold", 32'(crc_result), 32'h3A);

        // Overlength: 17 back-to-back bytes, engine silent while draining
        wait_ready();
        a0 = act_cnt; r0 = rdy_cnt; e0 = err_cnt; v0 = rv_cnt;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 7);
            if (i > 0) repeat (7) cyc();
            in_valid = 1'b1; in_data = b; in_last = 1'b0;
            if (i < 16) push_byte(b);
            cyc();
            in_valid = 1'b0;
        end
        wait_idle(60);
        cyc();
        chk("overlen_active", act_cnt - a0, 32'd128);
        chk("overlen_ready", rdy_cnt - r0, 32'd16);
        chk("overlen_error", err_cnt - e0, 32'd1);
        chk("overlen_no_result", rv_cnt - v0, 32'd0);
        chk("overlen_frame_bytes", 32'(frame_bytes), 32'd17);
        chk("overlen_crc_hold", 32'(crc_result), 32'h3A);

        // Engine slow to answer after the frame
        wait_ready();
        e0 = err_cnt; v0 = rv_cnt;
        in_valid = 1'b1; in_data = 8'h81; in_last = 1'b1;
        push_byte(8'h81);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (8) cyc();
`ifdef CRC_CTRL_TIMEOUT_EN
        hit = 0;
        for (int k = 1; k <= int'(2 * TIMEOUT_CYC); k++) begin
            cyc();
            if (err_cnt != e0) begin
                hit = k;
                break;
            end
        end
        chk("timeout_cycle", hit, TIMEOUT_CYC + 1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_no_result", rv_cnt - v0, 32'd0);
        chk("timeout_crc_hold", 32'(crc_result), 32'h3A);
`else
        hit = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (busy) hit++;
        end
        chk("wait_busy_held", hit, 32'd40);
        chk("wait_no_error", err_cnt - e0, 32'd0);
        exp_res.push_back('{crc: 8'h6B, fb: 1});
        engine(8'h6B, 8);
        repeat (3) cyc();
        chk("wait_result", rv_cnt - v0, 32'd1);
        chk("wait_crc", 32'(crc_result), 32'h6B);
        chk("wait_busy_clear", 32'(busy), 32'd0);
`endif

        // Reset at bit 4 of byte 2, then a fresh frame
        wait_ready();
        e0 = err_cnt;
        in_valid = 1'b1; in_data = 8'h3C; in_last = 1'b0;
        push_byte(8'h3C);
        cyc();
        in_valid = 1'b0;
        repeat (7) cyc();
        in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b1;
        push_byte(8'hF0);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_active", 32'(crc_active), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        exp_bits.delete();
        @(posedge CLK);
        #1;
        chk("midrst_crc_result", 32'(crc_result), 32'd0);
        chk("midrst_frame_bytes", 32'(frame_bytes), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_no_error_pulse", err_cnt - e0, 32'd0);
        run_vec(vecs[0]);

        chk("bits_queue_drained", exp_bits.size(), 32'd0);
        chk("result_queue_drained", exp_res.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
